// File: rtl/vr_source_pkg.sv
// Shared types and constants for the valid/ready traffic source.
// Also imported by checker models that predict the source's data stream.
package vr_source_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GAP   = 2'd1,
    OFFER = 2'd2,
    DONE  = 2'd3
  } state_e;

  typedef enum logic {
    MODE_INC  = 1'b0,
    MODE_LFSR = 1'b1
  } mode_e;

  // Maximal-length tap masks for a right-shifting Galois LFSR, keyed by register width.
  function automatic logic [63:0] lfsr_taps(input int width);
    case (width)
      4:       return 64'h0000_0000_0000_000C;
      5:       return 64'h0000_0000_0000_0014;
      6:       return 64'h0000_0000_0000_0030;
      7:       return 64'h0000_0000_0000_0060;
      8:       return 64'h0000_0000_0000_00B8;
      12:      return 64'h0000_0000_0000_0E08;
      16:      return 64'h0000_0000_0000_B400;
      24:      return 64'h0000_0000_00E1_0000;
      32:      return 64'h0000_0000_A300_0000;
      default: return 64'h0000_0000_0000_00B8;
    endcase
  endfunction

endpackage

// File: rtl/vr_source_if.sv
// Valid/ready bus: the master owns data and valid, the slave owns ready.
interface valid_ready #(
  parameter int DATA_WIDTH = 8
) ();
  logic [DATA_WIDTH-1:0] data;
  logic                  valid;
  logic                  ready;

  modport Master (output data, output valid, input ready);
  modport Slave  (input data, input valid, output ready);
endinterface

// File: rtl/vr_source_datagen.sv
// Combinational next-word function for the source data stream:
// increment, or one step of a right-shifting Galois LFSR.
module vr_source_datagen
  import vr_source_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] data_i,
  input  mode_e                 mode_i,
  output logic [DATA_WIDTH-1:0] next_o
);

  localparam logic [DATA_WIDTH-1:0] TAPS = DATA_WIDTH'(lfsr_taps(DATA_WIDTH));

  always_comb begin
    next_o = data_i + DATA_WIDTH'(1);
    if (mode_i == MODE_LFSR) begin
      next_o = (data_i >> 1) ^ (data_i[0] ? TAPS : '0);
    end
  end

endmodule

// File: rtl/vr_source.sv
// Valid/ready traffic generator: incrementing or LFSR words, a programmable
// idle gap between transfers, and an optional transfer-count limit per run.
module vr_source
  import vr_source_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DELAY_BITS = 3,
  parameter int COUNT_BITS = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [DELAY_BITS-1:0] delay,
  input  logic                  mode,
  input  logic [DATA_WIDTH-1:0] seed,
  input  logic [COUNT_BITS-1:0] num_xfers,
  output logic [COUNT_BITS-1:0] xfer_count,
  output logic                  done,
  valid_ready.Master            vrBus
);

  state_e                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic                    valid_q, valid_d;
  logic [COUNT_BITS-1:0]   xfer_count_q, xfer_count_d;
  logic                    done_q, done_d;
  logic [DELAY_BITS-1:0]   gap_cnt_q, gap_cnt_d;
  logic [DELAY_BITS-1:0]   gap_len_q, gap_len_d;

  logic [DATA_WIDTH-1:0]   next_word;
  logic [DATA_WIDTH-1:0]   start_word;
  logic [COUNT_BITS-1:0]   count_inc;
  logic                    handshake;

  vr_source_datagen #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_datagen (
    .data_i (data_q),
    .mode_i (mode_e'(mode)),
    .next_o (next_word)
  );

  // An all-zero LFSR state would lock up, so a zero seed starts from 1 instead.
  assign start_word = (mode_e'(mode) == MODE_LFSR && seed == '0) ? DATA_WIDTH'(1) : seed;
  assign count_inc  = xfer_count_q + COUNT_BITS'(1);
  assign handshake  = valid_q && vrBus.ready;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= IDLE;
      data_q       <= '0;
      valid_q      <= 1'b0;
      xfer_count_q <= '0;
      done_q       <= 1'b0;
      gap_cnt_q    <= '0;
      gap_len_q    <= '0;
    end else begin
      state_q      <= state_d;
      data_q       <= data_d;
      valid_q      <= valid_d;
      xfer_count_q <= xfer_count_d;
      done_q       <= done_d;
      gap_cnt_q    <= gap_cnt_d;
      gap_len_q    <= gap_len_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    data_d       = data_q;
    valid_d      = valid_q;
    xfer_count_d = xfer_count_q;
    done_d       = done_q;
    gap_cnt_d    = gap_cnt_q;
    gap_len_d    = gap_len_q;

    case (state_q)
      IDLE: begin
        valid_d = 1'b0;
        if (enable) begin
          data_d       = start_word;
          xfer_count_d = '0;
          done_d       = 1'b0;
          if (delay != '0) begin
            state_d   = GAP;
            gap_len_d = delay;
            gap_cnt_d = '0;
          end else begin
            state_d = OFFER;
            valid_d = 1'b1;
          end
        end
      end

      GAP: begin
        valid_d = 1'b0;
        if (!enable) begin
          state_d = IDLE;
        end else if (gap_cnt_q == gap_len_q - DELAY_BITS'(1)) begin
          state_d = OFFER;
          valid_d = 1'b1;
        end else begin
          gap_cnt_d = gap_cnt_q + DELAY_BITS'(1);
        end
      end

      // Enable is only honoured after a handshake: an offered word is never withdrawn.
      OFFER: begin
        if (handshake) begin
          data_d       = next_word;
          xfer_count_d = count_inc;
          if (num_xfers != '0 && count_inc == num_xfers) begin
            state_d = DONE;
            valid_d = 1'b0;
            done_d  = 1'b1;
          end else if (!enable) begin
            state_d = IDLE;
            valid_d = 1'b0;
          end else if (delay != '0) begin
            state_d   = GAP;
            valid_d   = 1'b0;
            gap_len_d = delay;
            gap_cnt_d = '0;
          end
        end
      end

      DONE: begin
        valid_d = 1'b0;
        done_d  = 1'b1;
        if (!enable) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  assign vrBus.data  = data_q;
  assign vrBus.valid = valid_q;
  assign xfer_count  = xfer_count_q;
  assign done        = done_q;

endmodule

// File: tb/tb_vr_source.sv
// Scoreboard bench for vr_source: stimulus queues the predicted word stream,
// a negedge monitor checks every handshake, gap length, hold stability and done.
module tb_vr_source;

  localparam int DW = 8;
  localparam int DB = 3;
  localparam int CB = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          enable = 1'b0;
  logic          mode = 1'b0;
  logic [DB-1:0] delay = '0;
  logic [DW-1:0] seed = '0;
  logic [CB-1:0] num_xfers = '0;
  logic [CB-1:0] xfer_count;
  logic          done;

  logic rdy_rand = 1'b0;
  logic rdy_rnd = 1'b0;
  logic rdy_fix = 1'b0;

  int vectors = 0;
  int miscompares = 0;

  logic [DW-1:0] exp_q[$];

  valid_ready #(.DATA_WIDTH(DW)) vr ();
  assign vr.ready = rdy_rand ? rdy_rnd : rdy_fix;

  vr_source #(
    .DATA_WIDTH (DW),
    .DELAY_BITS (DB),
    .COUNT_BITS (CB)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .delay      (delay),
    .mode       (mode),
    .seed       (seed),
    .num_xfers  (num_xfers),
    .xfer_count (xfer_count),
    .done       (done),
    .vrBus      (vr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    rdy_rnd = 1'($urandom_range(0, 1));
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model of the word stream: the sequence is a pure function of seed and mode.
  function automatic logic [DW-1:0] ref_next(input logic [DW-1:0] d, input logic m);
    logic [DW-1:0] taps;
    taps = 8'hB8;
    if (!m) return d + 8'd1;
    return d[0] ? ((d >> 1) ^ taps) : (d >> 1);
  endfunction

  task automatic push_run(input logic [DW-1:0] s, input logic m, input int n);
    logic [DW-1:0] w;
    w = (m && s == 0) ? 8'h01 : s;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(w);
      w = ref_next(w, m);
    end
  endtask

  // ---------------- monitor ----------------
  logic          prev_en = 1'b0, prev_rst = 1'b0, prev_valid = 1'b0, prev_hs = 1'b0;
  logic [DW-1:0] prev_data = '0;
  logic          armed = 1'b0, exp_done_next = 1'b0, hs = 1'b0, start = 1'b0;
  int            low_cnt = 0, run_hs = 0, hs_total = 0;
  logic [DW-1:0] exp_word;

  always @(negedge clk) begin
    hs = reset && vr.valid && vr.ready;
    if (!reset) begin
      armed = 1'b0;
      exp_done_next = 1'b0;
    end else begin
      start = enable && !(prev_en && prev_rst);
      if (exp_done_next) begin
        check("done_after_last", 32'(done), 32'd1);
        exp_done_next = 1'b0;
      end
      if (prev_valid && !prev_hs && prev_rst) begin
        check("hold_valid", 32'(vr.valid), 32'd1);
        check("hold_data", 32'(vr.data), 32'(prev_data));
      end
      if (!enable || done) armed = 1'b0;
      if (start) begin
        armed = 1'b1;
        low_cnt = 0;
        run_hs = 0;
      end else if (armed) begin
        if (vr.valid) begin
          check("gap_len", low_cnt, 32'(delay));
          armed = 1'b0;
        end else begin
          low_cnt++;
        end
      end
      if (hs) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_xfer: got data %0h expected no transfer", vr.data);
        end else begin
          exp_word = exp_q.pop_front();
          check("xfer_data", 32'(vr.data), 32'(exp_word));
        end
        check("xfer_count_at_hs", 32'(xfer_count), 32'(run_hs % 256));
        if (num_xfers != 0 && run_hs + 1 == int'(num_xfers)) exp_done_next = 1'b1;
        run_hs++;
        hs_total++;
        armed = 1'b1;
        low_cnt = 0;
      end
    end
    prev_en    = enable;
    prev_rst   = reset;
    prev_valid = vr.valid;
    prev_hs    = hs;
    prev_data  = vr.data;
  end

  // ---------------- stimulus ----------------
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_valid();
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (vr.valid) break;
    end
    check("wait_valid", 32'(vr.valid), 32'd1);
  endtask

  task automatic finish_run(input int n);
    @(negedge clk);
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (done) break;
    end
    check("run_done", 32'(done), 32'd1);
    check("run_count", 32'(xfer_count), 32'(n));
    check("queue_drained", exp_q.size(), 32'd0);
    @(posedge clk);
    #1;
    enable = 1'b0;
    rdy_rand = 1'b0;
    step(2);
  endtask

  task automatic run(input logic [DW-1:0] s, input logic m, input logic [DB-1:0] d,
                     input int n, input logic rr);
    exp_q.delete();
    push_run(s, m, n);
    seed = s;
    mode = m;
    delay = d;
    num_xfers = CB'(n);
    rdy_rand = rr;
    rdy_fix = 1'b1;
    enable = 1'b1;
    finish_run(n);
  endtask

  initial begin
    int base;
    // Reset held with enable high: outputs stay at reset values.
    reset = 1'b0; enable = 1'b1; delay = 3'd2; seed = 8'h30; mode = 1'b0;
    num_xfers = 8'd2; rdy_fix = 1'b1;
    push_run(8'h30, 1'b0, 2);
    repeat (3) begin
      @(negedge clk);
      check("rst_valid", 32'(vr.valid), 32'd0);
      check("rst_data", 32'(vr.data), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_count", 32'(xfer_count), 32'd0);
    end
    @(posedge clk); #1;
    reset = 1'b1;
    finish_run(2);

    run(8'hFD, 1'b0, 3'd0, 5, 1'b0);   // back-to-back with data wrap
    run(8'h20, 1'b0, 3'd3, 3, 1'b0);   // three-cycle gaps
    run(8'h01, 1'b1, 3'd0, 4, 1'b0);   // LFSR 01,B8,5C,2E
    run(8'h00, 1'b1, 3'd0, 2, 1'b0);   // zero LFSR seed starts at 01
    run(8'hA5, 1'b1, 3'd7, 4, 1'b1);   // longest gap under random ready

    // Backpressure: offered word held while enable drops, one handshake then idle.
    exp_q.delete();
    exp_q.push_back(8'h40);
    seed = 8'h40; mode = 1'b0; delay = 3'd0; num_xfers = 8'd0; rdy_fix = 1'b0; enable = 1'b1;
    wait_valid();
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (i == 1) enable = 1'b0;
      @(negedge clk);
      check("bp_valid", 32'(vr.valid), 32'd1);
      check("bp_data", 32'(vr.data), 32'h40);
    end
    @(posedge clk); #1;
    rdy_fix = 1'b1;
    @(posedge clk); #1;
    rdy_fix = 1'b0;
    @(negedge clk);
    check("bp_after_valid", 32'(vr.valid), 32'd0);
    check("bp_after_count", 32'(xfer_count), 32'd1);
    check("bp_queue", exp_q.size(), 32'd0);
    step(3);
    check("bp_idle_valid", 32'(vr.valid), 32'd0);

    // Reset while offering: no handshake counted, restart reloads the seed.
    exp_q.delete();
    seed = 8'h77; mode = 1'b0; delay = 3'd0; num_xfers = 8'd3; rdy_fix = 1'b0; enable = 1'b1;
    wait_valid();
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    check("midrst_valid", 32'(vr.valid), 32'd0);
    check("midrst_count", 32'(xfer_count), 32'd0);
    push_run(8'h77, 1'b0, 3);
    rdy_fix = 1'b1;
    finish_run(3);

    // Unlimited run long enough to wrap the transfer counter.
    exp_q.delete();
    push_run(8'h10, 1'b0, 300);
    seed = 8'h10; mode = 1'b0; delay = 3'd0; num_xfers = 8'd0; rdy_rand = 1'b1; enable = 1'b1;
    base = hs_total;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (hs_total - base >= 258) break;
    end
    check("wrap_reached", 32'(hs_total - base >= 258), 32'd1);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1; enable = 1'b0; rdy_rand = 1'b0;
    exp_q.delete();
    step(2);

    // Randomised runs.
    for (int r = 0; r < 10; r++) begin
      run(8'($urandom), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 4)),
          $urandom_range(1, 12), 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
